// File: rtl/qpll_reset_sequencer.sv
// qpll_reset_sequencer
//   Brings a group of GTYE4_COMMON QPLL0s out of reset together, waits for
//   all of them to lock, retries a bounded number of times on timeout and
//   parks in FAULT once the retries are used up. Lock losses seen after
//   lock are counted and trigger a fresh reset sequence.
//
//   Optional feature macro: QPLL_RESET_SEQ_DEBOUNCE_EN
//     defined   -> the combined lock must stay high for DEBOUNCE_CYCLES
//                  consecutive WAIT_LOCK cycles before it is accepted
//     undefined -> the combined lock is accepted on its first high cycle
//
// Ports
//   clk            control clock, all logic on its rising edge
//   rst_n          synchronous active-low reset
//   restart        single-cycle pulse, restarts sequencing from any state
//   qpll0lock      raw QPLL0 lock per quad (asynchronous, synchronised here)
//   qpll0reset     QPLL0 reset per quad, active-high, registered
//   qpll1reset     QPLL1 reset per quad, held at all-ones (QPLL1 unused)
//   all_locked     high only in LOCKED
//   fault          high only in FAULT
//   state          0 RESET_ASSERT, 1 WAIT_LOCK, 2 LOCKED, 3 FAULT
//   retry_cnt      failed lock attempts since the last lock or restart
//   lock_loss_cnt  lock losses seen in LOCKED, saturating at 0xFFFF
module qpll_reset_sequencer #(
  parameter int N_COMMON        = 2,
  parameter int RESET_CYCLES    = 64,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int MAX_RETRIES     = 3,
  parameter int DEBOUNCE_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [N_COMMON-1:0] qpll0lock,
  output logic [N_COMMON-1:0] qpll0reset,
  output logic [N_COMMON-1:0] qpll1reset,
  output logic                all_locked,
  output logic                fault,
  output logic [1:0]          state,
  output logic [3:0]          retry_cnt,
  output logic [15:0]         lock_loss_cnt
);

  typedef enum logic [1:0] {
    RESET_ASSERT = 2'd0,
    WAIT_LOCK    = 2'd1,
    LOCKED       = 2'd2,
    FAULT        = 2'd3
  } state_t;

  // One timer serves both the reset pulse and the lock timeout, so it is
  // sized for the longer of the two.
  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX);

  state_t                state_reg;
  logic [TW-1:0]         timer_reg;
  logic [N_COMMON-1:0]   lock_meta_reg;
  logic [N_COMMON-1:0]   lock_s;
  logic                  all_high;
  logic                  lock_qualified;

  // Two-flop synchroniser per quad.
  genvar gi;
  generate
    for (gi = 0; gi < N_COMMON; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lock_meta_reg[gi] <= 1'b0;
          lock_s[gi]        <= 1'b0;
        end else begin
          lock_meta_reg[gi] <= qpll0lock[gi];
          lock_s[gi]        <= lock_meta_reg[gi];
        end
      end
    end
  endgenerate

  assign all_high = &lock_s;

`ifdef QPLL_RESET_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] deb_cnt_reg;

  // Counts consecutive high cycles of the combined lock while in WAIT_LOCK;
  // anything else (low lock, other states, restart) starts it over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt_reg <= '0;
    end else if (state_reg == WAIT_LOCK && all_high && !restart) begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end else begin
      deb_cnt_reg <= '0;
    end
  end

  // The current cycle is the DEBOUNCE_CYCLES-th consecutive high one.
  assign lock_qualified = all_high && (deb_cnt_reg == DW'(DEBOUNCE_CYCLES - 1));
`else
  assign lock_qualified = all_high;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= RESET_ASSERT;
      timer_reg     <= '0;
      qpll0reset    <= '1;
      all_locked    <= 1'b0;
      fault         <= 1'b0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= 16'd0;
    end else if (restart) begin
      // Restart overrides whatever else happens this cycle, including any
      // counter increments from a coincident loss or timeout.
      state_reg  <= RESET_ASSERT;
      timer_reg  <= '0;
      qpll0reset <= '1;
      all_locked <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= 4'd0;
    end else begin
      case (state_reg)
        RESET_ASSERT: begin
          if (timer_reg == TW'(RESET_CYCLES - 1)) begin
            state_reg  <= WAIT_LOCK;
            timer_reg  <= '0;
            qpll0reset <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock is tested first so it wins over a same-cycle timeout.
          if (lock_qualified) begin
            state_reg  <= LOCKED;
            timer_reg  <= '0;
            all_locked <= 1'b1;
            retry_cnt  <= 4'd0;
          end else if (timer_reg == TW'(LOCK_TIMEOUT - 1)) begin
            timer_reg  <= '0;
            qpll0reset <= '1;
            if (retry_cnt == 4'(MAX_RETRIES)) begin
              state_reg <= FAULT;
              fault     <= 1'b1;
            end else begin
              state_reg <= RESET_ASSERT;
              retry_cnt <= retry_cnt + 4'd1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        LOCKED: begin
          if (!all_high) begin
            state_reg  <= RESET_ASSERT;
            timer_reg  <= '0;
            qpll0reset <= '1;
            all_locked <= 1'b0;
            if (lock_loss_cnt != 16'hFFFF) begin
              lock_loss_cnt <= lock_loss_cnt + 16'd1;
            end
          end
        end
        default: begin
          // FAULT holds until restart or reset.
          state_reg <= FAULT;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign qpll1reset = '1;

endmodule

// File: tb/tb_qpll_reset_sequencer.sv
// Testbench for qpll_reset_sequencer.
//   The driver applies one set of inputs per clock, advances a behavioural
//   model of the sequencing rules and pushes the expected post-edge outputs
//   into a scoreboard queue. A monitor on the falling edge pops and compares
//   every cycle, printing one line per state transition.
module tb_qpll_reset_sequencer;

  localparam int NC  = 2;
  localparam int RC  = 16;
  localparam int LT  = 1000;
  localparam int MR  = 3;
  localparam int DEB = 8;
`ifdef QPLL_RESET_SEQ_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic [NC-1:0] qpll0lock = '0;
  logic [NC-1:0] qpll0reset;
  logic [NC-1:0] qpll1reset;
  logic          all_locked;
  logic          fault;
  logic [1:0]    state;
  logic [3:0]    retry_cnt;
  logic [15:0]   lock_loss_cnt;

  qpll_reset_sequencer #(
    .N_COMMON(NC), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
    .MAX_RETRIES(MR), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .qpll0lock(qpll0lock),
    .qpll0reset(qpll0reset), .qpll1reset(qpll1reset), .all_locked(all_locked),
    .fault(fault), .state(state), .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  q0;
    logic [1:0]  q1;
    logic        al;
    logic        flt;
    logic [3:0]  retry;
    logic [15:0] losses;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: phase follows the spec's state numbering; age is the
  // number of cycles already spent in the current phase; stable is the run
  // of consecutive all-high synchronised lock cycles inside WAIT_LOCK.
  int         m_phase = 0, m_age = 0, m_stable = 0, m_retries = 0, m_losses = 0;
  logic [1:0] m_meta = 2'b00, m_s = 2'b00;

  task automatic model_step(input logic r, input logic rs, input logic [1:0] lk);
    bit all_high, qualified;
    all_high = (m_s == 2'b11);
    if (!r) begin
      m_phase = 0; m_age = 0; m_stable = 0; m_retries = 0; m_losses = 0;
      m_meta = 2'b00; m_s = 2'b00;
    end else begin
      if (rs) begin
        m_phase = 0; m_age = 0; m_stable = 0; m_retries = 0;
      end else begin
        case (m_phase)
          0: if (m_age == RC - 1) begin m_phase = 1; m_age = 0; m_stable = 0; end
             else m_age++;
          1: begin
            qualified = all_high && (!DEB_EN || (m_stable + 1 >= DEB));
            if (qualified) begin
              m_phase = 2; m_retries = 0; m_age = 0;
            end else if (m_age == LT - 1) begin
              m_age = 0;
              if (m_retries == MR) m_phase = 3;
              else begin m_retries++; m_phase = 0; end
            end else begin
              m_age++;
              m_stable = all_high ? m_stable + 1 : 0;
            end
          end
          2: if (!all_high) begin
               if (m_losses < 65535) m_losses++;
               m_phase = 0; m_age = 0;
             end
          default: ;
        endcase
      end
      m_s    = m_meta;
      m_meta = lk;
    end
  endtask

  // Apply one cycle of inputs, predict the outcome of the coming edge,
  // then return #1 after that edge.
  task automatic step(input logic r, input logic rs, input logic [1:0] lk);
    exp_t e;
    rst_n = r; restart = rs; qpll0lock = lk;
    model_step(r, rs, lk);
    e.st     = 2'(m_phase);
    e.q0     = (m_phase == 0 || m_phase == 3) ? 2'b11 : 2'b00;
    e.q1     = 2'b11;
    e.al     = (m_phase == 2);
    e.flt    = (m_phase == 3);
    e.retry  = 4'(m_retries);
    e.losses = 16'(m_losses);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin : monitor
    exp_t       e;
    logic [1:0] prev_state = 2'bxx;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("qpll0reset", 32'(qpll0reset), 32'(e.q0));
        check("qpll1reset", 32'(qpll1reset), 32'(e.q1));
        check("all_locked", 32'(all_locked), 32'(e.al));
        check("fault", 32'(fault), 32'(e.flt));
        check("retry_cnt", 32'(retry_cnt), 32'(e.retry));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.losses));
        if (state !== prev_state)
          $display("t=%0t state %0d -> %0d retry=%0d losses=%0d qpll0reset=%b",
                   $time, prev_state, state, retry_cnt, lock_loss_cnt, qpll0reset);
        prev_state = state;
      end
    end
  end

  initial begin : driver
    int lock_cyc;
    lock_cyc = DEB_EN ? (100 + 2 + DEB) : (100 + 2 + 1);

    // Power-up: both locks rise at cycle 100.
    repeat (3) step(1'b0, 1'b0, 2'b00);
    for (int c = 0; c < 160; c++) begin
      step(1'b1, 1'b0, (c >= 100) ? 2'b11 : 2'b00);
      if (c == 14)           check("pwrup_q0_c15", 32'(qpll0reset), 32'd3);
      if (c == 15)           check("pwrup_q0_c16", 32'(qpll0reset), 32'd0);
      if (c == lock_cyc - 2) check("pwrup_locked_early", 32'(all_locked), 32'd0);
      if (c == lock_cyc - 1) check("pwrup_locked_on_time", 32'(all_locked), 32'd1);
    end

    // Single-cycle loss on lock[0], then relock.
    repeat (10) step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    repeat (100) step(1'b1, 1'b0, 2'b11);
    check("relock_losses", 32'(lock_loss_cnt), 32'd1);
    check("relock_retry", 32'(retry_cnt), 32'd0);

    // Restart coinciding with the synchronised lock loss.
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    check("restart_loss_state", 32'(state), 32'd0);
    check("restart_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    repeat (100) step(1'b1, 1'b0, 2'b11);

    // lock[1] never rises: retries exhaust, FAULT, then restart.
    repeat (4150) step(1'b1, 1'b0, 2'b01);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_state", 32'(state), 32'd3);
    check("fault_q0", 32'(qpll0reset), 32'd3);
    check("fault_retry", 32'(retry_cnt), 32'(MR));
    step(1'b1, 1'b1, 2'b01);
    check("fault_restart_flag", 32'(fault), 32'd0);
    check("fault_restart_state", 32'(state), 32'd0);
    check("fault_restart_retry", 32'(retry_cnt), 32'd0);
    repeat (150) step(1'b1, 1'b0, 2'b11);

    // Chattering lock: high 5 / low 1, never stable long enough to debounce.
    step(1'b1, 1'b1, 2'b00);
    for (int c = 0; c < 1100; c++)
      step(1'b1, 1'b0, ((c % 6) < 5) ? 2'b11 : 2'b00);
    check("chatter_retry", 32'(retry_cnt), DEB_EN ? 32'd1 : 32'd0);

    // Randomised lock glitches, restarts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] lk;
      logic       rs, r;
      lk = ($urandom_range(0, 99) < 97) ? 2'b11 : 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 299) == 0);
      r  = ($urandom_range(0, 999) != 0);
      step(r, rs, lk);
    end

    // Reset in the middle of WAIT_LOCK.
    step(1'b1, 1'b1, 2'b00);
    repeat (30) step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    check("rst_state", 32'(state), 32'd0);
    check("rst_q0", 32'(qpll0reset), 32'd3);
    check("rst_q1", 32'(qpll1reset), 32'd3);
    check("rst_locked", 32'(all_locked), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_losses", 32'(lock_loss_cnt), 32'd0);
    repeat (40) step(1'b1, 1'b0, 2'b11);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
